// File: rtl/tlb_pkg.sv
// Shared constants for the TLB instruction sequencer: op codes, invtlb ops,
// ELO field layout and the controller state encoding.
package tlb_pkg;

  localparam logic [2:0] TLBOP_SRCH = 3'd1;
  localparam logic [2:0] TLBOP_RD   = 3'd2;
  localparam logic [2:0] TLBOP_WR   = 3'd3;
  localparam logic [2:0] TLBOP_FILL = 3'd4;
  localparam logic [2:0] TLBOP_INV  = 3'd5;

  localparam logic [4:0] INVTLB_ALL       = 5'd0;
  localparam logic [4:0] INVTLB_ALL1      = 5'd1;
  localparam logic [4:0] INVTLB_G         = 5'd2;
  localparam logic [4:0] INVTLB_NG        = 5'd3;
  localparam logic [4:0] INVTLB_NG_ASID   = 5'd4;
  localparam logic [4:0] INVTLB_ASID_VA   = 5'd5;
  localparam logic [4:0] INVTLB_G_ASID_VA = 5'd6;

  // ELO packing: {ppn[19:0], g, mat[1:0], plv[1:0], d, v}
  localparam int ELO_W   = 27;
  localparam int ELO_V   = 0;
  localparam int ELO_D   = 1;
  localparam int ELO_PLV = 2;
  localparam int ELO_MAT = 4;
  localparam int ELO_G   = 6;
  localparam int ELO_PPN = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } tlb_state_t;

  function automatic logic op_legal(input logic [2:0] code);
    return (code >= TLBOP_SRCH) && (code <= TLBOP_INV);
  endfunction

endpackage

// File: rtl/tlb_fill_ctr.sv
// Free-running wrap counter that picks the victim slot for TLBFILL.
module tlb_fill_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequences TLB instructions one at a time (accept -> EXEC -> DONE) and
// borrows TLB search port 1 from the load/store path for SRCH and INV.
module tlb_op_ctrl
  import tlb_pkg::*;
#(
  parameter  int TLBNUM = 16,
  localparam int IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [2:0]      op_code,
  input  logic [4:0]      inv_op,
  input  logic [9:0]      inv_asid,
  input  logic [31:0]     inv_va,
  input  logic            flush,
  input  logic [IDXW-1:0] csr_index,
  input  logic [5:0]      csr_ps,
  input  logic            csr_ne,
  input  logic [18:0]     csr_vppn,
  input  logic [9:0]      csr_asid,
  input  logic [26:0]     csr_elo0,
  input  logic [26:0]     csr_elo1,
  input  logic [18:0]     mem_vppn,
  input  logic [9:0]      mem_asid,
  input  logic            mem_bit12,
  output logic            mem_s1_busy,
  output logic [18:0]     s1_vppn,
  output logic [9:0]      s1_asid,
  output logic            s1_va_bit12,
  input  logic            s1_found,
  input  logic [IDXW-1:0] s1_index,
  output logic            we,
  output logic [IDXW-1:0] w_index,
  output logic            w_e,
  output logic [18:0]     w_vppn,
  output logic [5:0]      w_ps,
  output logic [9:0]      w_asid,
  output logic            w_g,
  output logic [19:0]     w_ppn0,
  output logic [1:0]      w_plv0,
  output logic [1:0]      w_mat0,
  output logic            w_d0,
  output logic            w_v0,
  output logic [19:0]     w_ppn1,
  output logic [1:0]      w_plv1,
  output logic [1:0]      w_mat1,
  output logic            w_d1,
  output logic            w_v1,
  output logic [IDXW-1:0] r_index,
  output logic            invtlb_valid,
  output logic [4:0]      invtlb_op,
  output logic            done,
  output logic            srch_hit,
  output logic [IDXW-1:0] srch_index,
  output logic            inv_err
);

  tlb_state_t state, state_nx;

  logic [IDXW-1:0]  fill_cnt;
  logic             accept;
  logic [2:0]       op_q;
  logic [4:0]       inv_op_q;
  logic [9:0]       inv_asid_q;
  logic [31:12]     inv_va_q;
  logic [IDXW-1:0]  idx_q, fill_q, r_index_q;
  logic [5:0]       ps_q;
  logic             ne_q;
  logic [18:0]      vppn_q;
  logic [9:0]       asid_q;
  logic [ELO_W-1:0] elo0_q, elo1_q;
  logic             in_exec, is_srch, is_inv, inv_ok, op_err;
  logic             unused_va;

  assign unused_va = ^inv_va[11:0];

  tlb_fill_ctr #(.W(IDXW)) u_fill_ctr (
    .clk   (clk),
    .reset (reset),
    .cnt   (fill_cnt)
  );

  assign op_ready = (state == ST_IDLE);
  assign accept   = op_valid & op_ready & ~flush & ~reset;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = ST_EXEC;
      ST_EXEC: state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Operand snapshot; the CSRs may change while the op is in flight.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q       <= op_code;
      inv_op_q   <= inv_op;
      inv_asid_q <= inv_asid;
      inv_va_q   <= inv_va[31:12];
      idx_q      <= csr_index;
      ps_q       <= csr_ps;
      ne_q       <= csr_ne;
      vppn_q     <= csr_vppn;
      asid_q     <= csr_asid;
      elo0_q     <= csr_elo0;
      elo1_q     <= csr_elo1;
      if (op_code == TLBOP_FILL) fill_q <= fill_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                              r_index_q <= '0;
    else if (accept && op_code == TLBOP_RD) r_index_q <= csr_index;
  end

  // The read index is visible already in the accept cycle.
  assign r_index = (accept && op_code == TLBOP_RD) ? csr_index : r_index_q;

  // Reset kills any in-flight side effect in the same cycle.
  assign in_exec = (state == ST_EXEC) & ~reset;
  assign is_srch = (op_q == TLBOP_SRCH);
  assign is_inv  = (op_q == TLBOP_INV);
  assign inv_ok  = (inv_op_q <= INVTLB_G_ASID_VA);
  assign op_err  = ~op_legal(op_q) | (is_inv & ~inv_ok);

  assign we           = in_exec & ((op_q == TLBOP_WR) | (op_q == TLBOP_FILL));
  assign invtlb_valid = in_exec & is_inv & inv_ok;
  assign invtlb_op    = inv_op_q;
  assign mem_s1_busy  = in_exec & (is_srch | is_inv);
  assign done         = (state == ST_DONE) & ~reset;

  always_comb begin
    s1_vppn     = mem_vppn;
    s1_asid     = mem_asid;
    s1_va_bit12 = mem_bit12;
    if (mem_s1_busy) begin
      if (is_srch) begin
        s1_vppn     = vppn_q;
        s1_asid     = asid_q;
        s1_va_bit12 = 1'b0;
      end else begin
        s1_vppn     = inv_va_q[31:13];
        s1_asid     = inv_asid_q;
        s1_va_bit12 = inv_va_q[12];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      srch_hit   <= 1'b0;
      srch_index <= '0;
      inv_err    <= 1'b0;
    end else begin
      inv_err <= in_exec & op_err;
      if (in_exec)           srch_hit   <= is_srch & s1_found;
      if (in_exec & is_srch) srch_index <= s1_index;
    end
  end

  assign w_index = (op_q == TLBOP_FILL) ? fill_q : idx_q;
  assign w_e     = ~ne_q;
  assign w_vppn  = vppn_q;
  assign w_ps    = ps_q;
  assign w_asid  = asid_q;
  assign w_g     = elo0_q[ELO_G] & elo1_q[ELO_G];
  assign w_ppn0  = elo0_q[ELO_PPN +: 20];
  assign w_plv0  = elo0_q[ELO_PLV +: 2];
  assign w_mat0  = elo0_q[ELO_MAT +: 2];
  assign w_d0    = elo0_q[ELO_D];
  assign w_v0    = elo0_q[ELO_V];
  assign w_ppn1  = elo1_q[ELO_PPN +: 20];
  assign w_plv1  = elo1_q[ELO_PLV +: 2];
  assign w_mat1  = elo1_q[ELO_MAT +: 2];
  assign w_d1    = elo1_q[ELO_D];
  assign w_v1    = elo1_q[ELO_V];

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl: a small TLB array, a cycle-level reference
// model checked every cycle, and literal expectations for the key scenarios.
module tb_tlb_op_ctrl;

  logic        clk, reset;
  logic        op_valid, op_ready, flush;
  logic [2:0]  op_code;
  logic [4:0]  inv_op;
  logic [9:0]  inv_asid;
  logic [31:0] inv_va;
  logic [3:0]  csr_index;
  logic [5:0]  csr_ps;
  logic        csr_ne;
  logic [18:0] csr_vppn;
  logic [9:0]  csr_asid;
  logic [26:0] csr_elo0, csr_elo1;
  logic [18:0] mem_vppn;
  logic [9:0]  mem_asid;
  logic        mem_bit12, mem_s1_busy;
  logic [18:0] s1_vppn;
  logic [9:0]  s1_asid;
  logic        s1_va_bit12, s1_found;
  logic [3:0]  s1_index;
  logic        we, w_e, w_g;
  logic [3:0]  w_index;
  logic [18:0] w_vppn;
  logic [5:0]  w_ps;
  logic [9:0]  w_asid;
  logic [19:0] w_ppn0, w_ppn1;
  logic [1:0]  w_plv0, w_mat0, w_plv1, w_mat1;
  logic        w_d0, w_v0, w_d1, w_v1;
  logic [3:0]  r_index;
  logic        invtlb_valid;
  logic [4:0]  invtlb_op;
  logic        done, srch_hit, inv_err;
  logic [3:0]  srch_index;

  tlb_op_ctrl #(.TLBNUM(16)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .inv_op(inv_op), .inv_asid(inv_asid), .inv_va(inv_va),
    .flush(flush), .csr_index(csr_index), .csr_ps(csr_ps), .csr_ne(csr_ne),
    .csr_vppn(csr_vppn), .csr_asid(csr_asid), .csr_elo0(csr_elo0), .csr_elo1(csr_elo1),
    .mem_vppn(mem_vppn), .mem_asid(mem_asid), .mem_bit12(mem_bit12),
    .mem_s1_busy(mem_s1_busy), .s1_vppn(s1_vppn), .s1_asid(s1_asid),
    .s1_va_bit12(s1_va_bit12), .s1_found(s1_found), .s1_index(s1_index),
    .we(we), .w_index(w_index), .w_e(w_e), .w_vppn(w_vppn), .w_ps(w_ps),
    .w_asid(w_asid), .w_g(w_g),
    .w_ppn0(w_ppn0), .w_plv0(w_plv0), .w_mat0(w_mat0), .w_d0(w_d0), .w_v0(w_v0),
    .w_ppn1(w_ppn1), .w_plv1(w_plv1), .w_mat1(w_mat1), .w_d1(w_d1), .w_v1(w_v1),
    .r_index(r_index), .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op),
    .done(done), .srch_hit(srch_hit), .srch_index(srch_index), .inv_err(inv_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- TLB array environment ----------------
  logic        tlb_e    [16];
  logic [18:0] tlb_vppn [16];
  logic [9:0]  tlb_asid [16];
  logic        tlb_g    [16];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) tlb_e[i] <= 1'b0;
    end else if (we) begin
      tlb_e[w_index]    <= w_e;
      tlb_vppn[w_index] <= w_vppn;
      tlb_asid[w_index] <= w_asid;
      tlb_g[w_index]    <= w_g;
    end
  end

  function automatic void lookup(input logic [18:0] v, input logic [9:0] a,
                                 output logic f, output logic [3:0] idx);
    f = 1'b0; idx = 4'd0;
    for (int i = 15; i >= 0; i--)
      if (tlb_e[i] && tlb_vppn[i] == v && (tlb_g[i] || tlb_asid[i] == a)) begin
        f = 1'b1; idx = i[3:0];
      end
  endfunction

  always_comb lookup(s1_vppn, s1_asid, s1_found, s1_index);

  // ---------------- reference model + per-cycle compare ----------------
  logic        m_valid = 1'b0;
  int          m_acc = 0, m_free = 0, m_t0 = 0;
  logic [2:0]  m_code;
  logic [4:0]  m_inv_op;
  logic [9:0]  m_inv_asid, m_asid;
  logic [31:0] m_va;
  logic [3:0]  m_idx, m_fill, m_rd = 4'd0, m_hidx;
  logic [5:0]  m_ps;
  logic        m_ne, m_hit;
  logic [18:0] m_vppn;
  logic [26:0] m_elo0, m_elo1;

  int          we_cnt = 0, inv_cnt = 0, dbl_done = 0, cap_done_cyc = 0;
  logic [3:0]  cap_w_index, cap_hidx, cap_r_index;
  logic        cap_w_e, cap_inv_busy, cap_hit, cap_err, cap_r_e, prev_done = 1'b0;
  logic [18:0] cap_inv_vppn, cap_r_vppn;
  int          acc_q[$];

  always @(negedge clk) begin
    logic x_exec, x_done, x_we, x_inv, x_busy;
    logic [18:0] xv;
    logic [9:0]  xa;
    x_exec = m_valid && cyc == m_acc + 1 && !reset;
    x_done = m_valid && cyc == m_acc + 2 && !reset;
    x_we   = x_exec && (m_code == 3'd3 || m_code == 3'd4);
    x_inv  = x_exec && m_code == 3'd5 && m_inv_op <= 5'd6;
    x_busy = x_exec && (m_code == 3'd1 || m_code == 3'd5);

    chk("op_ready", op_ready, cyc >= m_free);
    chk("we", we, x_we);
    chk("invtlb_valid", invtlb_valid, x_inv);
    chk("mem_s1_busy", mem_s1_busy, x_busy);
    chk("done", done, x_done);

    xv = mem_vppn; xa = mem_asid;
    if (x_busy && m_code == 3'd1) begin xv = m_vppn; xa = m_asid; end
    if (x_busy && m_code == 3'd5) begin xv = m_va[31:13]; xa = m_inv_asid; end
    chk("s1_vppn", s1_vppn, xv);
    chk("s1_asid", s1_asid, xa);
    if (!x_busy)                    chk("s1_bit12", s1_va_bit12, mem_bit12);
    if (x_busy && m_code == 3'd1)   chk("s1_bit12_srch", s1_va_bit12, 1'b0);

    if (x_we) begin
      chk("w_index", w_index, (m_code == 3'd3) ? m_idx : m_fill);
      chk("w_e", w_e, !m_ne);
      chk("w_vppn", w_vppn, m_vppn);
      chk("w_ps", w_ps, m_ps);
      chk("w_asid", w_asid, m_asid);
      chk("w_g", w_g, m_elo0[6] & m_elo1[6]);
      chk("w_ppn0", w_ppn0, m_elo0[26:7]);
      chk("w_lo0", {w_mat0, w_plv0, w_d0, w_v0}, {m_elo0[5:4], m_elo0[3:2], m_elo0[1], m_elo0[0]});
      chk("w_ppn1", w_ppn1, m_elo1[26:7]);
      chk("w_lo1", {w_mat1, w_plv1, w_d1, w_v1}, {m_elo1[5:4], m_elo1[3:2], m_elo1[1], m_elo1[0]});
    end
    if (x_inv) chk("invtlb_op", invtlb_op, m_inv_op);
    if (x_exec && m_code == 3'd1) lookup(m_vppn, m_asid, m_hit, m_hidx);
    if (x_done) begin
      chk("inv_err", inv_err, !(m_code >= 3'd1 && m_code <= 3'd5) || (m_code == 3'd5 && m_inv_op > 5'd6));
      if (m_code == 3'd1) begin
        chk("srch_hit", srch_hit, m_hit);
        if (m_hit) chk("srch_index", srch_index, m_hidx);
      end
    end

    // observations used by the literal checks
    if (we) begin we_cnt++; cap_w_index = w_index; cap_w_e = w_e; end
    if (invtlb_valid) begin inv_cnt++; cap_inv_vppn = s1_vppn; cap_inv_busy = mem_s1_busy; end
    if (done) begin
      cap_done_cyc = cyc; cap_hit = srch_hit; cap_hidx = srch_index; cap_err = inv_err;
      cap_r_index = r_index; cap_r_e = tlb_e[r_index]; cap_r_vppn = tlb_vppn[r_index];
    end
    if (done && prev_done) dbl_done++;
    prev_done = done;
    if (op_valid && op_ready && !flush && !reset) acc_q.push_back(cyc);

    // model state update
    if (reset) begin
      m_valid = 1'b0; m_free = cyc + 1; m_t0 = cyc + 1; m_rd = 4'd0;
    end else if (op_valid && !flush && cyc >= m_free) begin
      m_valid = 1'b1; m_acc = cyc; m_free = cyc + 3;
      m_code = op_code; m_inv_op = inv_op; m_inv_asid = inv_asid; m_va = inv_va;
      m_idx = csr_index; m_ps = csr_ps; m_ne = csr_ne; m_vppn = csr_vppn;
      m_asid = csr_asid; m_elo0 = csr_elo0; m_elo1 = csr_elo1;
      m_fill = 4'((cyc - m_t0) % 16);
      if (op_code == 3'd2) m_rd = csr_index;
    end
    if (!reset) chk("r_index", r_index, m_rd);
  end

  // ---------------- directed stimulus ----------------
  task automatic issue(input logic [2:0] code, output int acc);
    bit got;
    got = 1'b0; acc = -1;
    op_code = code; op_valid = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (op_ready) begin got = 1'b1; acc = cyc; end
      @(posedge clk); #1;
      if (got) break;
    end
    op_valid = 1'b0;
    chk("accept_timeout", got, 1'b1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int acc, base, nacc, dbl0;
    reset = 1'b1; op_valid = 0; flush = 0; op_code = 0;
    inv_op = 0; inv_asid = 0; inv_va = 0;
    csr_index = 0; csr_ps = 6'd12; csr_ne = 0; csr_vppn = 0; csr_asid = 0;
    csr_elo0 = 0; csr_elo1 = 0; mem_vppn = 19'h01111; mem_asid = 10'h011; mem_bit12 = 1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_op_ready", op_ready, 1);
    chk("rst_outs", {we, invtlb_valid, done, srch_hit, inv_err, mem_s1_busy}, 6'd0);
    chk("rst_srch_index", srch_index, 0);
    chk("rst_r_index", r_index, 0);
    @(posedge clk); #1;

    // FILL at counter 15, then 3 cycles later at counter 2
    csr_vppn = 19'h00100; csr_asid = 10'd1; csr_elo0 = {20'h11111, 1'b1, 2'b10, 2'b01, 1'b0, 1'b1};
    csr_elo1 = {20'h22222, 1'b1, 2'b01, 2'b11, 1'b1, 1'b0};
    for (int n = 0; n < 20 && ((cyc - m_t0) % 16) != 15; n++) begin @(posedge clk); #1; end
    base = we_cnt;
    issue(3'd4, acc);
    chk("fill_idx_15", cap_w_index, 4'd15);
    csr_vppn = 19'h00200;
    issue(3'd4, acc);
    chk("fill_idx_wrap", cap_w_index, 4'd2);
    chk("fill_we_count", we_cnt - base, 2);

    // WR entry 5 then SRCH hit / miss
    csr_index = 4'd5; csr_vppn = 19'h12345; csr_asid = 10'd3; csr_ne = 0; csr_ps = 6'd21;
    csr_elo0 = {20'hABCDE, 1'b0, 2'b01, 2'b00, 1'b1, 1'b1};
    csr_elo1 = {20'h0F0F0, 1'b1, 2'b11, 2'b10, 1'b0, 1'b1};
    issue(3'd3, acc);
    issue(3'd1, acc);
    chk("srch_latency", cap_done_cyc, acc + 2);
    chk("srch_hit_lit", cap_hit, 1);
    chk("srch_index_lit", cap_hidx, 4'd5);
    csr_asid = 10'd4;
    issue(3'd1, acc);
    chk("srch_miss_lit", cap_hit, 0);

    // WR index 9 with NE=1, then RD it back
    csr_index = 4'd9; csr_ne = 1; csr_vppn = 19'h0ABCD; csr_asid = 10'd7;
    base = we_cnt;
    issue(3'd3, acc);
    chk("wr_we_once", we_cnt - base, 1);
    chk("wr_w_index", cap_w_index, 4'd9);
    chk("wr_w_e", cap_w_e, 0);
    csr_index = 4'd9; csr_ne = 0; csr_vppn = 19'h0;
    issue(3'd2, acc);
    chk("rd_r_index", cap_r_index, 4'd9);
    chk("rd_r_e", cap_r_e, 0);
    chk("rd_r_vppn", cap_r_vppn, 19'h0ABCD);

    // INV legal and illegal
    inv_op = 5'd5; inv_asid = 10'd3; inv_va = 32'h2468A000; mem_vppn = 19'h7ABCD;
    base = inv_cnt;
    issue(3'd5, acc);
    chk("inv_once", inv_cnt - base, 1);
    chk("inv_s1_vppn", cap_inv_vppn, 19'h12345);
    chk("inv_busy", cap_inv_busy, 1);
    chk("inv_ok_err", cap_err, 0);
    inv_op = 5'd7;
    base = inv_cnt;
    issue(3'd5, acc);
    chk("inv7_none", inv_cnt - base, 0);
    chk("inv7_err", cap_err, 1);

    // illegal op_code
    base = we_cnt;
    issue(3'd6, acc);
    chk("badop_err", cap_err, 1);
    chk("badop_no_we", we_cnt - base, 0);

    // flush blocks acceptance
    nacc = acc_q.size();
    flush = 1; op_valid = 1; op_code = 3'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("flush_ready", op_ready, 1);
    chk("flush_no_accept", acc_q.size() - nacc, 0);
    @(posedge clk); #1 flush = 0; op_valid = 0;

    // reset during EXEC of a WR
    csr_index = 4'd12; csr_ne = 0;
    base = we_cnt;
    op_code = 3'd3; op_valid = 1;
    @(negedge clk);
    chk("rstwr_ready", op_ready, 1);
    @(posedge clk); #1 op_valid = 0; reset = 1;
    @(negedge clk);
    chk("rstwr_we", we, 0);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("rstwr_idle", op_ready, 1);
    chk("rstwr_done", done, 0);
    chk("rstwr_no_write", we_cnt - base, 0);
    @(posedge clk); #1;

    // back-to-back with op_valid held
    csr_vppn = 19'h12345; csr_asid = 10'd3;
    nacc = acc_q.size(); dbl0 = dbl_done;
    op_code = 3'd1; op_valid = 1;
    repeat (12) @(posedge clk);
    #1 op_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_count", acc_q.size() - nacc, 4);
    for (int i = nacc + 1; i < acc_q.size(); i++)
      chk("b2b_spacing", acc_q[i] - acc_q[i-1], 3);
    chk("b2b_no_dbl_done", dbl_done - dbl0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tlb_op_ctrl.md
Name: tlb_op_ctrl

Overview:
- Sequencer between the EXE/MEM stage and the TLB array; executes TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB one at a time through a valid/ready handshake.
- Drives the TLB write port, read index and invtlb controls from CSR-supplied fields.
- Arbitrates TLB search port 1 between the load/store path and the controller.
- Returns search results and a completion pulse to the CSR/writeback logic.

Parameters:
- TLBNUM, 16, number of TLB entries; must be a power of two.
- IDXW, $clog2(TLBNUM), index width (derived, not overridable).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- op_valid  in  1  TLB instruction request
- op_ready  out  1  controller idle and able to accept
- op_code  in  3  1=SRCH 2=RD 3=WR 4=FILL 5=INV; other values are illegal
- inv_op  in  5  invtlb op field
- inv_asid  in  10  invtlb rj[9:0]
- inv_va  in  32  invtlb rk
- flush  in  1  pipeline flush (exception/ertn)
- csr_index  in  IDXW  TLBIDX.Index
- csr_ps  in  6  TLBIDX.PS
- csr_ne  in  1  TLBIDX.NE
- csr_vppn  in  19  TLBEHI.VPPN
- csr_asid  in  10  ASID.ASID
- csr_elo0, csr_elo1  in  27 each  packed {ppn[19:0], g, mat[1:0], plv[1:0], d, v}
- mem_vppn, mem_asid, mem_bit12  in  19/10/1  load/store lookup request
- mem_s1_busy  out  1  port 1 is taken by the controller; the mem stage must stall
- s1_vppn, s1_asid, s1_va_bit12  out  19/10/1  to TLB search port 1
- s1_found, s1_index  in  1/IDXW  from TLB
- we, w_index, w_e, w_vppn, w_ps, w_asid, w_g  out  1/IDXW/1/19/6/10/1  to TLB write port
- w_ppn0/plv0/mat0/d0/v0 and w_ppn1/plv1/mat1/d1/v1  out  unpacked from csr_elo0 and csr_elo1
- r_index  out  IDXW  TLB read index
- invtlb_valid, invtlb_op  out  1/5
- done  out  1  one-cycle completion pulse
- srch_hit, srch_index  out  1/IDXW  TLBSRCH result, valid while done=1
- inv_err  out  1  illegal invtlb_op (>6) or illegal op_code, valid while done=1

Behaviour:
- FSM states: IDLE, EXEC, DONE.
- Reset: state=IDLE; op_ready=1; we, invtlb_valid, done, srch_hit, inv_err, mem_s1_busy all 0; srch_index=0; r_index=0; fill counter=0.
- op_ready = (state==IDLE). Accept condition: op_valid & op_ready & ~flush. Flush in the same cycle means the op is not accepted.
- On accept, latch op_code, inv_op, inv_asid, inv_va and all csr_* inputs. Go to EXEC.
- On accept with op_code FILL, also latch the fill counter as the write index.
- EXEC lasts exactly one cycle, then DONE for one cycle (done=1), then IDLE. Latency from accept to done is 2 cycles. Next accept is possible in the cycle after DONE.
- After acceptance, flush does not cancel the op; the op completes.
- Fill counter: free-running IDXW-bit increment every cycle, wrapping TLBNUM-1 -> 0, including while busy.
- SRCH in EXEC: s1_vppn=latched csr_vppn, s1_asid=latched csr_asid, s1_va_bit12=0. Register srch_hit=s1_found and srch_index=s1_index, presented in DONE.
- RD: r_index=latched csr_index from the accept cycle onward. r_index holds until the next accepted RD. The CSR unit samples r_* during DONE.
- WR/FILL: we=1 in EXEC only. w_index = csr_index for WR, latched counter for FILL. w_e = ~csr_ne; w_ps = csr_ps; w_vppn = csr_vppn; w_asid = csr_asid; w_g = elo0.g & elo1.g.
- INV: if inv_op ≤ 6, invtlb_valid=1 in EXEC with invtlb_op=inv_op, s1_vppn=inv_va[31:13], s1_asid=inv_asid. If inv_op > 6, no invtlb_valid; inv_err=1 in DONE.
- Illegal op_code: no TLB side effect; inv_err=1 in DONE.
- Port 1 arbitration: mem_s1_busy=1 in EXEC when the op is SRCH or INV. Otherwise s1_* = mem_* passthrough. The controller always wins; there is no starvation concern because the port is held for 1 cycle per op.
- we and invtlb_valid are never both 1. Both are 0 outside EXEC.
- Reset mid-operation: immediate return to IDLE; any pending we/invtlb_valid/done is dropped.

Decomposition:
- Package tlb_pkg holds:
  - op_code constants (TLBOP_SRCH..TLBOP_INV);
  - invtlb op constants 0–6;
  - ELO packed-field bit offsets;
  - FSM state encoding.
- One sub-module, tlb_fill_ctr: free-running wrap counter with reset; IDXW wide.

Test Plan:
- Entry 5 written with vppn=0x12345, asid=3, g=0; SRCH with csr_vppn=0x12345, asid=3 -> done at accept+2, srch_hit=1, srch_index=5; repeat with asid=4 -> srch_hit=0.
- WR with csr_index=9, ne=1 -> we=1 for exactly one cycle in EXEC, w_index=9, w_e=0; following RD index 9 -> r_e=0 sampled in DONE.
- FILL accepted when counter=15 -> w_index=15; next FILL accepted 3 cycles later -> w_index=2 (wrap verified).
- INV op=5, asid=3, va=0x2468A000 -> invtlb_valid=1 for one cycle, s1_vppn=0x12345, mem_s1_busy=1 in that cycle, mem request stalled; INV op=7 -> invtlb_valid never asserted, inv_err=1.
- op_valid with flush=1 -> op_ready stays 1, no EXEC; reset asserted in EXEC of a WR -> we deasserted that cycle, state IDLE, done=0.
- Back-to-back ops with op_valid held high -> accepts spaced exactly 3 cycles apart; done never asserted in consecutive cycles.
